// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package mips_mem_pkg;

    localparam int MEM_DATA_W       = 16;
    localparam int MEM_ADDR_W       = 16;
    localparam int MEM_ARB_MAX_WAIT = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_PIPE = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating DMA starvation counter; hit flags that DMA has lost MAX_WAIT
// consecutive cycles and must be forced through.
module mem_arb_starve_ctr
    import mips_mem_pkg::*;
#(
    parameter int MAX_WAIT = MEM_ARB_MAX_WAIT
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0] count_r;

    // Count losing cycles, clear on grant or withdrawn request, saturate at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= 4'd0;
        end else if (clr) begin
            count_r <= 4'd0;
        end else if (inc && (count_r != MAX_WAIT_C)) begin
            count_r <= count_r + 4'd1;
        end
    end

    assign hit = (count_r == MAX_WAIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Pipe/DMA arbiter for the single-ported data memory.
// Define MEM_ARB_STARVE_EN to compile in the forced-DMA anti-starvation path.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int DATA_W   = MEM_DATA_W,
    parameter int ADDR_W   = MEM_ADDR_W,
    parameter int MAX_WAIT = MEM_ARB_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_req,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_wdata,
    output logic              pipe_gnt,
    output logic              pipe_stall,
    output logic              pipe_rvalid,
    output logic [DATA_W-1:0] pipe_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output owner_t            arb_owner
);

    if ((MAX_WAIT < 1) || (MAX_WAIT > 15)) begin : g_bad_max_wait
        $error("mem_port_arbiter: MAX_WAIT must be in 1..15");
    end

    logic              starve_hit_s;
    logic              pipe_win_s;
    logic              dma_win_s;
    owner_t            owner_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] hold_addr_r;
    logic [DATA_W-1:0] hold_wdata_r;
    logic              pipe_rvalid_r;
    logic [DATA_W-1:0] pipe_rdata_r;
    logic              dma_rvalid_r;
    logic [DATA_W-1:0] dma_rdata_r;

`ifdef MEM_ARB_STARVE_EN
    mem_arb_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_ctr (
        .clk (clk),
        .rst (rst),
        .inc (dma_req & ~dma_win_s),
        .clr (dma_win_s | ~dma_req),
        .hit (starve_hit_s)
    );
`else
    assign starve_hit_s = 1'b0;
`endif

    // Grant selection: pipe first unless DMA has hit its wait limit; nothing while in reset.
    always_comb begin
        pipe_win_s = 1'b0;
        dma_win_s  = 1'b0;
        owner_s    = OWN_NONE;
        if (rst) begin
            owner_s = OWN_NONE;
        end else if (pipe_req && !(dma_req && starve_hit_s)) begin
            pipe_win_s = 1'b1;
            owner_s    = OWN_PIPE;
        end else if (dma_req) begin
            dma_win_s = 1'b1;
            owner_s   = OWN_DMA;
        end else begin
            owner_s = OWN_NONE;
        end
    end

    // Memory drive from the winner; address/data park on their last values when idle.
    always_comb begin
        mem_addr_s  = hold_addr_r;
        mem_wdata_s = hold_wdata_r;
        mem_we_s    = 1'b0;
        if (pipe_win_s) begin
            mem_addr_s  = pipe_addr;
            mem_wdata_s = pipe_wdata;
            mem_we_s    = pipe_we;
        end else if (dma_win_s) begin
            mem_addr_s  = dma_addr;
            mem_wdata_s = dma_wdata;
            mem_we_s    = dma_we;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Park registers for the idle memory bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_addr_r  <= '0;
            hold_wdata_r <= '0;
        end else begin
            hold_addr_r  <= mem_addr_s;
            hold_wdata_r <= mem_wdata_s;
        end
    end

    // Read responses: capture memory data for the granted reader and pulse its valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_rvalid_r <= 1'b0;
            pipe_rdata_r  <= '0;
            dma_rvalid_r  <= 1'b0;
            dma_rdata_r   <= '0;
        end else begin
            pipe_rvalid_r <= pipe_win_s & ~pipe_we;
            dma_rvalid_r  <= dma_win_s & ~dma_we;
            if (pipe_win_s && !pipe_we) begin
                pipe_rdata_r <= mem_rdata;
            end
            if (dma_win_s && !dma_we) begin
                dma_rdata_r <= mem_rdata;
            end
        end
    end

    assign pipe_gnt    = pipe_win_s;
    assign dma_gnt     = dma_win_s;
    assign pipe_stall  = pipe_req & ~pipe_win_s;
    assign mem_addr    = mem_addr_s;
    assign mem_wdata   = mem_wdata_s;
    assign mem_we      = mem_we_s;
    assign arb_owner   = owner_s;
    assign pipe_rvalid = pipe_rvalid_r;
    assign pipe_rdata  = pipe_rdata_r;
    assign dma_rvalid  = dma_rvalid_r;
    assign dma_rdata   = dma_rdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus starvation and reset sequences.
module tb_mem_port_arbiter;
    import mips_mem_pkg::*;

    logic        clk;
    logic        rst;
    logic        pipe_req, pipe_we, pipe_gnt, pipe_stall, pipe_rvalid;
    logic [15:0] pipe_addr, pipe_wdata, pipe_rdata;
    logic        dma_req, dma_we, dma_gnt, dma_rvalid;
    logic [15:0] dma_addr, dma_wdata, dma_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    owner_t      arb_owner;

    logic [15:0] mem [0:255];
    int checks;
    int errors;
    int vidx;

`ifdef MEM_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    mem_port_arbiter #(.DATA_W(16), .ADDR_W(16), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .pipe_req(pipe_req), .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
        .pipe_gnt(pipe_gnt), .pipe_stall(pipe_stall), .pipe_rvalid(pipe_rvalid), .pipe_rdata(pipe_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .arb_owner(arb_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;

    typedef struct {
        logic        preq, pwe;
        logic [15:0] paddr, pwdata;
        logic        dreq, dwe;
        logic [15:0] daddr, dwdata;
        logic        e_pg, e_dg, e_stall, e_mwe;
        logic [15:0] e_maddr, e_mwdata;
        logic [1:0]  e_own;
        logic        e_prv;
        logic [15:0] e_prd;
        logic        e_drv;
        logic [15:0] e_drd;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (step %0d): got %0h expected %0h", name, vidx, act, exp);
        end
    endtask

    task automatic drive(input logic preq, input logic pwe, input logic [15:0] paddr, input logic [15:0] pwdata,
                         input logic dreq, input logic dwe, input logic [15:0] daddr, input logic [15:0] dwdata);
        pipe_req = preq; pipe_we = pwe; pipe_addr = paddr; pipe_wdata = pwdata;
        dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_wdata = dwdata;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vidx   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h10] = 16'hBEEF;
        mem[8'h01] = 16'h00AA;
        mem[8'h02] = 16'h00BB;

        //          preq pwe  paddr     pwdata    dreq dwe  daddr     dwdata    pg   dg   stl  mwe  maddr     mwdata    own   prv  prd       drv  drd
        vecs[0]  = '{1'b1,1'b0,16'h0010,16'h0000,1'b0,1'b0,16'h0000,16'h0000,1'b1,1'b0,1'b0,1'b0,16'h0010,16'h0000,2'd1,1'b1,16'hBEEF,1'b0,16'h0000};
        vecs[1]  = '{1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0,1'b0,16'h0010,16'h0000,2'd0,1'b0,16'hBEEF,1'b0,16'h0000};
        vecs[2]  = '{1'b1,1'b1,16'h0020,16'h1234,1'b1,1'b0,16'h0020,16'h0000,1'b1,1'b0,1'b0,1'b1,16'h0020,16'h1234,2'd1,1'b0,16'hBEEF,1'b0,16'h0000};
        vecs[3]  = '{1'b0,1'b0,16'h0000,16'h0000,1'b1,1'b0,16'h0020,16'h0000,1'b0,1'b1,1'b0,1'b0,16'h0020,16'h0000,2'd2,1'b0,16'hBEEF,1'b1,16'h1234};
        vecs[4]  = '{1'b1,1'b0,16'h0001,16'h0000,1'b0,1'b0,16'h0000,16'h0000,1'b1,1'b0,1'b0,1'b0,16'h0001,16'h0000,2'd1,1'b1,16'h00AA,1'b0,16'h1234};
        vecs[5]  = '{1'b1,1'b0,16'h0002,16'h0000,1'b0,1'b0,16'h0000,16'h0000,1'b1,1'b0,1'b0,1'b0,16'h0002,16'h0000,2'd1,1'b1,16'h00BB,1'b0,16'h1234};
        vecs[6]  = '{1'b0,1'b0,16'h0000,16'h0000,1'b1,1'b1,16'h0030,16'h5555,1'b0,1'b1,1'b0,1'b1,16'h0030,16'h5555,2'd2,1'b0,16'h00BB,1'b0,16'h1234};
        vecs[7]  = '{1'b1,1'b1,16'h0040,16'h1111,1'b1,1'b1,16'h0040,16'h2222,1'b1,1'b0,1'b0,1'b1,16'h0040,16'h1111,2'd1,1'b0,16'h00BB,1'b0,16'h1234};
        vecs[8]  = '{1'b0,1'b0,16'h0000,16'h0000,1'b1,1'b1,16'h0040,16'h2222,1'b0,1'b1,1'b0,1'b1,16'h0040,16'h2222,2'd2,1'b0,16'h00BB,1'b0,16'h1234};
        vecs[9]  = '{1'b0,1'b0,16'h0000,16'h0000,1'b1,1'b0,16'h0040,16'h0000,1'b0,1'b1,1'b0,1'b0,16'h0040,16'h0000,2'd2,1'b0,16'h00BB,1'b1,16'h2222};
        vecs[10] = '{1'b1,1'b0,16'h0030,16'h0000,1'b0,1'b0,16'h0000,16'h0000,1'b1,1'b0,1'b0,1'b0,16'h0030,16'h0000,2'd1,1'b1,16'h5555,1'b0,16'h2222};
        vecs[11] = '{1'b1,1'b0,16'h0050,16'h0000,1'b1,1'b0,16'h0010,16'h0000,1'b1,1'b0,1'b0,1'b0,16'h0050,16'h0000,2'd1,1'b1,16'h0000,1'b0,16'h2222};
        vecs[12] = '{1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0,1'b0,16'h0050,16'h0000,2'd0,1'b0,16'h0000,1'b0,16'h2222};

        // Reset with a pending pipe request: nothing granted, everything zero.
        rst = 1'b1;
        drive(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h0002, 16'h0000);
        @(posedge clk); @(posedge clk); #1;
        chk("rst_pipe_gnt", 32'(pipe_gnt), 32'd0);
        chk("rst_dma_gnt", 32'(dma_gnt), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_owner", 32'(arb_owner), 32'd0);
        chk("rst_pipe_rvalid", 32'(pipe_rvalid), 32'd0);
        chk("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
        chk("rst_pipe_rdata", 32'(pipe_rdata), 32'd0);
        chk("rst_dma_rdata", 32'(dma_rdata), 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            vidx = i;
            @(negedge clk);
            drive(vecs[i].preq, vecs[i].pwe, vecs[i].paddr, vecs[i].pwdata,
                  vecs[i].dreq, vecs[i].dwe, vecs[i].daddr, vecs[i].dwdata);
            #1;
            chk("pipe_gnt", 32'(pipe_gnt), 32'(vecs[i].e_pg));
            chk("dma_gnt", 32'(dma_gnt), 32'(vecs[i].e_dg));
            chk("pipe_stall", 32'(pipe_stall), 32'(vecs[i].e_stall));
            chk("mem_we", 32'(mem_we), 32'(vecs[i].e_mwe));
            chk("mem_addr", 32'(mem_addr), 32'(vecs[i].e_maddr));
            chk("mem_wdata", 32'(mem_wdata), 32'(vecs[i].e_mwdata));
            chk("arb_owner", 32'(arb_owner), 32'(vecs[i].e_own));
            @(posedge clk); #1;
            chk("pipe_rvalid", 32'(pipe_rvalid), 32'(vecs[i].e_prv));
            chk("pipe_rdata", 32'(pipe_rdata), 32'(vecs[i].e_prd));
            chk("dma_rvalid", 32'(dma_rvalid), 32'(vecs[i].e_drv));
            chk("dma_rdata", 32'(dma_rdata), 32'(vecs[i].e_drd));
        end

        // Continuous pipe load with a waiting DMA read.
        for (int c = 0; c < 8; c++) begin
            logic forced;
            vidx = 100 + c;
            forced = STARVE_ON && (c == 4);
            @(negedge clk);
            drive(1'b1, 1'b0, 16'h0001, 16'h0000, 1'b1, 1'b0, 16'h0002, 16'h0000);
            #1;
            chk("starve_dma_gnt", 32'(dma_gnt), 32'(forced));
            chk("starve_pipe_gnt", 32'(pipe_gnt), 32'(!forced));
            chk("starve_pipe_stall", 32'(pipe_stall), 32'(forced));
            @(posedge clk); #1;
            chk("starve_dma_rvalid", 32'(dma_rvalid), 32'(forced));
            chk("starve_pipe_rdata", 32'(pipe_rdata), 32'h00AA);
        end
        vidx = 108;
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0002, 16'h0000);
        #1;
        chk("pipe_drop_dma_gnt", 32'(dma_gnt), 32'd1);
        chk("pipe_drop_owner", 32'(arb_owner), 32'(OWN_DMA));
        @(posedge clk); #1;
        chk("pipe_drop_dma_rdata", 32'(dma_rdata), 32'h00BB);

        // Reset asserted between a DMA read grant and its capture edge.
        vidx = 200;
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h0000);
        #1;
        chk("midrd_dma_gnt", 32'(dma_gnt), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("midrd_gnt_in_rst", 32'(dma_gnt), 32'd0);
        @(posedge clk); #1;
        chk("midrd_dma_rvalid", 32'(dma_rvalid), 32'd0);
        chk("midrd_dma_rdata", 32'(dma_rdata), 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            vidx = 201 + c;
            @(posedge clk); #1;
            chk("post_rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
            chk("post_rst_pipe_rvalid", 32'(pipe_rvalid), 32'd0);
            chk("post_rst_dma_rdata", 32'(dma_rdata), 32'd0);
            chk("post_rst_pipe_rdata", 32'(pipe_rdata), 32'd0);
            chk("post_rst_mem_addr", 32'(mem_addr), 32'd0);
            chk("post_rst_mem_we", 32'(mem_we), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
